// File: rtl/ipv4_head_rx.sv
// Receive-side IPv4 header parser: checks the header beat by beat and forwards a
// length-trimmed payload stream for accepted packets, dropping rejected ones.
module ipv4_head_rx #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W = 16,
    parameter int unsigned ADDR_W = 32,
    parameter logic [ADDR_W-1:0] LOCAL_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [7:0] PROTOCOL = 8'd17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              cancel_i,
    output logic              hdr_v_o,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [LEN_W-1:0]  data_len_o,
    output logic              data_v_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        data_keep_o,
    output logic              data_last_o,
    output logic              err_v_o,
    output logic [4:0]        err_o
);

    typedef enum logic [2:0] {StIdle, StHead, StOpt, StData, StDrop} state_t;

    state_t state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [15:0] csum_q, csum_d, cs_q, cs_d;
    logic [3:0] ver_q, ver_d, ihl_q, ihl_d;
    logic [LEN_W-1:0] tot_len_q, tot_len_d, rem_q, rem_d;
    logic frag_q, frag_d;
    logic [7:0] proto_q, proto_d;
    logic [15:0] src_lo_q, src_lo_d, src_hi_q, src_hi_d, dst_lo_q, dst_lo_d, dst_hi_q, dst_hi_d;

    logic hdr_v_d, data_v_d, data_last_d, err_v_d;
    logic [DATA_W-1:0] data_d;
    logic [1:0] keep_d;
    logic [4:0] err_d;
    logic [ADDR_W-1:0] src_d;
    logic [LEN_W-1:0] len_d;

    logic in_pkt, decide, reject;
    logic [15:0] csum_beat;
    logic [ADDR_W-1:0] dst_full;
    logic [LEN_W-1:0] hdr_bytes, pay_len;
    logic [4:0] errs;

    assign in_pkt    = (state_q == StHead) || (state_q == StOpt) || (state_q == StData);
    // w5 carries the checksum itself and is excluded from the running sum
    assign csum_beat = csum_q + ((cnt_q == 5'd5) ? 16'd0 : data_i);
    // At w9 the high dst word is still on the input; in OPT it has been stored
    assign dst_full  = (state_q == StHead) ? {data_i, dst_lo_q} : {dst_hi_q, dst_lo_q};
    assign hdr_bytes = {{(LEN_W-6){1'b0}}, ihl_q, 2'b00};
    assign pay_len   = tot_len_q - hdr_bytes;

    always_comb begin
        errs[0] = (ver_q != 4'd4) || (ihl_q < 4'd5) || (tot_len_q < hdr_bytes);
        errs[1] = frag_q;
        errs[2] = (proto_q != PROTOCOL);
        errs[3] = (dst_full != LOCAL_ADDR);
        errs[4] = (csum_beat != cs_q);
    end
    assign reject = |errs;

    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;        csum_d = csum_q;     cs_d = cs_q;
        ver_d = ver_q;      ihl_d = ihl_q;        tot_len_d = tot_len_q;
        rem_d = rem_q;      frag_d = frag_q;      proto_d = proto_q;
        src_lo_d = src_lo_q; src_hi_d = src_hi_q; dst_lo_d = dst_lo_q; dst_hi_d = dst_hi_q;
        hdr_v_d = 1'b0;     data_v_d = 1'b0;      data_last_d = 1'b0;  err_v_d = 1'b0;
        data_d = data_o;    keep_d = 2'b00;       err_d = err_o;
        src_d = src_addr_o; len_d = data_len_o;
        decide = 1'b0;

        if (cancel_i && in_pkt) begin
            state_d = StIdle;
        end else if (valid_i && start_i) begin
            ver_d   = data_i[3:0];
            ihl_d   = data_i[7:4];
            csum_d  = data_i;
            cnt_d   = 5'd1;
            state_d = StHead;
        end else if (valid_i) begin
            case (state_q)
                StHead: begin
                    cnt_d  = cnt_q + 5'd1;
                    csum_d = csum_beat;
                    case (cnt_q)
                        5'd1: tot_len_d = data_i;
                        5'd3: frag_d = (data_i[15:3] != 13'd0);
                        5'd4: proto_d = data_i[15:8];
                        5'd5: cs_d = data_i;
                        5'd6: src_lo_d = data_i;
                        5'd7: src_hi_d = data_i;
                        5'd8: dst_lo_d = data_i;
                        5'd9: dst_hi_d = data_i;
                        default: ;
                    endcase
                    if (cnt_q == 5'd9) begin
                        if (ihl_q > 4'd5) state_d = StOpt;
                        else decide = 1'b1;
                    end
                end
                StOpt: begin
                    cnt_d  = cnt_q + 5'd1;
                    csum_d = csum_beat;
                    if (cnt_q == {ihl_q, 1'b0} - 5'd1) decide = 1'b1;
                end
                StData: begin
                    data_v_d = 1'b1;
                    data_d   = data_i;
                    rem_d    = rem_q - LEN_W'(2);
                    if (rem_q <= LEN_W'(2)) begin
                        data_last_d = 1'b1;
                        keep_d      = (rem_q == LEN_W'(1)) ? 2'b01 : 2'b11;
                        state_d     = StDrop;
                    end else begin
                        keep_d = 2'b11;
                    end
                end
                default: ;
            endcase
        end

        if (decide) begin
            if (reject) begin
                err_v_d = 1'b1;
                err_d   = errs;
                state_d = StDrop;
            end else begin
                hdr_v_d = 1'b1;
                src_d   = {src_hi_q, src_lo_q};
                len_d   = pay_len;
                rem_d   = pay_len;
                state_d = (pay_len == '0) ? StIdle : StData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;  cnt_q <= '0;      csum_q <= '0;     cs_q <= '0;
            ver_q <= '0;        ihl_q <= '0;      tot_len_q <= '0;  rem_q <= '0;
            frag_q <= 1'b0;     proto_q <= '0;
            src_lo_q <= '0;     src_hi_q <= '0;   dst_lo_q <= '0;   dst_hi_q <= '0;
            hdr_v_o <= 1'b0;    data_v_o <= 1'b0; data_last_o <= 1'b0; err_v_o <= 1'b0;
            data_o <= '0;       data_keep_o <= '0; err_o <= '0;
            src_addr_o <= '0;   data_len_o <= '0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d;   csum_q <= csum_d; cs_q <= cs_d;
            ver_q <= ver_d;     ihl_q <= ihl_d;   tot_len_q <= tot_len_d; rem_q <= rem_d;
            frag_q <= frag_d;   proto_q <= proto_d;
            src_lo_q <= src_lo_d; src_hi_q <= src_hi_d; dst_lo_q <= dst_lo_d; dst_hi_q <= dst_hi_d;
            hdr_v_o <= hdr_v_d; data_v_o <= data_v_d; data_last_o <= data_last_d;
            err_v_o <= err_v_d;
            data_o <= data_d;   data_keep_o <= keep_d; err_o <= err_d;
            src_addr_o <= src_d; data_len_o <= len_d;
        end
    end

endmodule

// File: tb/tb_ipv4_head_rx.sv
// Directed bench for ipv4_head_rx: good/bad headers, options, padding, cancel, restart, reset.
module tb_ipv4_head_rx;

    localparam logic [31:0] LOCAL = 32'hCEC8_7F80;
    localparam logic [31:0] SRC   = 32'h0A00_0002;

    logic clk = 1'b0;
    logic rst, valid_i, start_i, cancel_i;
    logic [15:0] data_i;
    logic hdr_v_o, data_v_o, data_last_o, err_v_o;
    logic [31:0] src_addr_o;
    logic [15:0] data_len_o, data_o;
    logic [1:0] data_keep_o;
    logic [4:0] err_o;

    int vectors = 0, miscompares = 0;
    int hdr_cnt = 0, err_cnt = 0, dv_cnt = 0, last_cnt = 0;
    int b_hdr, b_err, b_dv, b_last;
    logic [1:0] last_keep = 2'b00;
    logic [15:0] hw [16];
    int hn;

    ipv4_head_rx dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .start_i(start_i), .data_i(data_i),
        .cancel_i(cancel_i), .hdr_v_o(hdr_v_o), .src_addr_o(src_addr_o),
        .data_len_o(data_len_o), .data_v_o(data_v_o), .data_o(data_o),
        .data_keep_o(data_keep_o), .data_last_o(data_last_o), .err_v_o(err_v_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hdr_v_o) hdr_cnt++;
        if (err_v_o) err_cnt++;
        if (data_v_o) begin
            dv_cnt++;
            if (data_last_o) begin
                last_cnt++;
                last_keep = data_keep_o;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic st, input logic cn, input logic [15:0] d);
        valid_i = 1'b1; start_i = st; cancel_i = cn; data_i = d;
        @(posedge clk); #1;
        valid_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic snap();
        b_hdr = hdr_cnt; b_err = err_cnt; b_dv = dv_cnt; b_last = last_cnt;
    endtask

    task automatic fix_cs();
        logic [15:0] s;
        s = 16'h0000;
        for (int i = 0; i < hn; i++) if (i != 5) s = s + hw[i];
        hw[5] = s;
    endtask

    task automatic make_hdr(input logic [15:0] tot, input logic [7:0] proto,
                            input logic [31:0] dst);
        hn = 10;
        hw[0] = 16'h0054; hw[1] = tot;        hw[2] = 16'h1234; hw[3] = 16'h0000;
        hw[4] = {proto, 8'd64}; hw[5] = 16'h0000;
        hw[6] = SRC[15:0];      hw[7] = SRC[31:16];
        hw[8] = dst[15:0];      hw[9] = dst[31:16];
        fix_cs();
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) beat(i == 0, 1'b0, hw[i]);
    endtask

    task automatic payload(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 16'hA001 + 16'(i));
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0; data_i = '0;
        idle(2);
        rst = 1'b0;
        chk("rst_hdr_v", 32'(hdr_v_o), 32'd0);
        chk("rst_data_v", 32'(data_v_o), 32'd0);
        chk("rst_err_v", 32'(err_v_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_keep", 32'(data_keep_o), 32'd0);
        chk("rst_len", 32'(data_len_o), 32'd0);

        // Default header, data_len 8, 4 payload beats plus 3 padding beats
        snap();
        make_hdr(16'd28, 8'd17, LOCAL);
        chk("a_cs_const", 32'(hw[5]), 32'h7C2E);
        send_range(0, 9);
        chk("a_hdr_v", 32'(hdr_v_o), 32'd1);
        chk("a_len", 32'(data_len_o), 32'd8);
        chk("a_src", src_addr_o, SRC);
        chk("a_err_v", 32'(err_v_o), 32'd0);
        beat(1'b0, 1'b0, 16'hA001);
        chk("a_first_v", 32'(data_v_o), 32'd1);
        chk("a_first_d", 32'(data_o), 32'hA001);
        chk("a_first_nolast", 32'(data_last_o), 32'd0);
        beat(1'b0, 1'b0, 16'hA002);
        beat(1'b0, 1'b0, 16'hA003);
        beat(1'b0, 1'b0, 16'hA004);
        chk("a_last", 32'(data_last_o), 32'd1);
        chk("a_keep", 32'(data_keep_o), 32'b11);
        chk("a_last_d", 32'(data_o), 32'hA004);
        beat(1'b0, 1'b0, 16'h0000);
        beat(1'b0, 1'b0, 16'h0000);
        beat(1'b0, 1'b0, 16'h0000);
        idle(2);
        chk("a_dv_count", 32'(dv_cnt - b_dv), 32'd4);
        chk("a_hdr_count", 32'(hdr_cnt - b_hdr), 32'd1);

        // data_len 5: odd tail
        snap();
        make_hdr(16'd25, 8'd17, LOCAL);
        send_range(0, 9);
        chk("b_len", 32'(data_len_o), 32'd5);
        payload(3);
        chk("b_last", 32'(data_last_o), 32'd1);
        chk("b_keep", 32'(data_keep_o), 32'b01);
        payload(2);
        idle(2);
        chk("b_dv_count", 32'(dv_cnt - b_dv), 32'd3);

        // Bad checksum, then a good packet
        snap();
        make_hdr(16'd28, 8'd17, LOCAL);
        hw[5] = hw[5] + 16'd1;
        send_range(0, 9);
        chk("c_err_v", 32'(err_v_o), 32'd1);
        chk("c_err", 32'(err_o), 32'b10000);
        chk("c_hdr_v", 32'(hdr_v_o), 32'd0);
        payload(4);
        idle(2);
        chk("c_dv_count", 32'(dv_cnt - b_dv), 32'd0);
        make_hdr(16'd28, 8'd17, LOCAL);
        send_range(0, 9);
        chk("c_good_hdr_v", 32'(hdr_v_o), 32'd1);
        chk("c_err_sticky", 32'(err_o), 32'b10000);
        payload(4);
        idle(2);
        chk("c_dv_count2", 32'(dv_cnt - b_dv), 32'd4);

        // Wrong dst and protocol
        make_hdr(16'd28, 8'd6, 32'h0A00_0001);
        send_range(0, 9);
        chk("d_err_v", 32'(err_v_o), 32'd1);
        chk("d_err", 32'(err_o), 32'b01100);

        // IHL 6 with two option words
        snap();
        make_hdr(16'd32, 8'd17, LOCAL);
        hw[0] = 16'h0064; hn = 12; hw[10] = 16'h0101; hw[11] = 16'h0202;
        fix_cs();
        send_range(0, 9);
        chk("e_no_hdr_at_w9", 32'(hdr_v_o), 32'd0);
        send_range(10, 11);
        chk("e_hdr_v", 32'(hdr_v_o), 32'd1);
        chk("e_len", 32'(data_len_o), 32'd8);
        payload(4);
        chk("e_last", 32'(data_last_o), 32'd1);
        idle(2);
        chk("e_dv_count", 32'(dv_cnt - b_dv), 32'd4);

        // Zero-length payload: nothing forwarded after the header
        snap();
        make_hdr(16'd20, 8'd17, LOCAL);
        send_range(0, 9);
        chk("z_hdr_v", 32'(hdr_v_o), 32'd1);
        chk("z_len", 32'(data_len_o), 32'd0);
        payload(2);
        idle(2);
        chk("z_dv_count", 32'(dv_cnt - b_dv), 32'd0);

        // cancel at w4, then restart mid-payload
        snap();
        make_hdr(16'd28, 8'd17, LOCAL);
        send_range(0, 3);
        beat(1'b0, 1'b1, hw[4]);
        send_range(5, 9);
        idle(2);
        chk("f_cancel_hdr", 32'(hdr_cnt - b_hdr), 32'd0);
        chk("f_cancel_err", 32'(err_cnt - b_err), 32'd0);
        send_range(0, 9);
        payload(2);
        send_range(0, 9);
        payload(4);
        idle(2);
        chk("f_restart_hdr", 32'(hdr_cnt - b_hdr), 32'd2);
        chk("f_restart_last", 32'(last_cnt - b_last), 32'd1);
        chk("f_restart_dv", 32'(dv_cnt - b_dv), 32'd6);
        chk("f_restart_err", 32'(err_cnt - b_err), 32'd0);

        // Reset mid-header
        snap();
        send_range(0, 4);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("g_err", 32'(err_o), 32'd0);
        chk("g_src", src_addr_o, 32'd0);
        chk("g_len", 32'(data_len_o), 32'd0);
        chk("g_hdr_v", 32'(hdr_v_o), 32'd0);
        send_range(5, 9);
        idle(2);
        chk("g_ignored_hdr", 32'(hdr_cnt - b_hdr), 32'd0);
        chk("g_ignored_err", 32'(err_cnt - b_err), 32'd0);
        send_range(0, 9);
        chk("g_clean_hdr_v", 32'(hdr_v_o), 32'd1);
        chk("g_clean_src", src_addr_o, SRC);
        payload(4);
        idle(2);
        chk("g_clean_dv", 32'(dv_cnt - b_dv), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
